// File: rtl/fetch_queue_if.sv
// Bundle of fetch-queue signals: instruction-memory port, decode handshake,
// redirect input and occupancy status. "master" is the fetch-queue side.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus4;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic [CW-1:0]   occupancy;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output instr_pc_plus4,
        input  redirect_valid,
        input  redirect_pc,
        output occupancy
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  instr_pc_plus4,
        output redirect_valid,
        output redirect_pc,
        input  occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: PC, single-cycle-latency imem requests, and a
// {instr, pc} FIFO towards decode with redirect flush of FIFO and in-flight reads.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
        return a + XLEN'(4);
    endfunction

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [XLEN-1:0] fifo_instr_q [DEPTH];
    logic [XLEN-1:0] fifo_instr_d [DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [XLEN-1:0] fifo_pc_d    [DEPTH];

    logic            resp_valid;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic            req;
    logic [CW:0]     credit_sum;

    always_comb begin
        // A response only exists the cycle after a request, unless a redirect killed it.
        resp_valid = inflight_q & ~kill_q;
        head_valid = ~rst & (occ_q != '0) & ~bus.redirect_valid;
        pop        = head_valid & bus.instr_ready;
        push       = resp_valid & ~bus.redirect_valid & ~rst;

        // Credit counts buffered entries plus the read still in flight, less what leaves now.
        credit_sum = {1'b0, occ_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        req        = ~rst & ~bus.redirect_valid & (credit_sum < DEPTH_W);
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req;
        kill_d     = bus.redirect_valid;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;

        if (req) begin
            pc_d     = next_word(pc_q);
            req_pc_d = pc_q;
        end

        if (bus.redirect_valid) begin
            pc_d     = word_align(bus.redirect_pc);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            occ_d    = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        if (push) begin
            fifo_instr_d[wr_ptr_q] = bus.imem_rdata;
            fifo_pc_d[wr_ptr_q]    = req_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= word_align(RESET_PC);
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // Payload storage carries no reset; it is only read behind a nonzero occupancy.
    always_ff @(posedge clk) begin
        req_pc_q     <= req_pc_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

    always_comb begin
        bus.imem_req       = req;
        bus.imem_addr      = pc_q;
        bus.instr_valid    = head_valid;
        bus.instr          = fifo_instr_q[rd_ptr_q];
        bus.instr_pc       = fifo_pc_q[rd_ptr_q];
        bus.instr_pc_plus4 = next_word(fifo_pc_q[rd_ptr_q]);
        bus.occupancy      = occ_q;
    end

    a_no_push_into_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (occ_q == FULL)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sync imem model returning addr ^ 0xA5A50000,
// hand-computed cycle-by-cycle expectations for fetch, backpressure, redirect and reset.
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus_if ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the request, X otherwise.
    always @(posedge clk) begin
        if (bus_if.imem_req) bus_if.imem_rdata <= bus_if.imem_addr ^ KEY;
        else                 bus_if.imem_rdata <= 'x;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        logic [31:0] p4;
        logic [31:0] ins;
        p4  = pc + 32'd4;
        ins = pc ^ KEY;
        chk({tag, "_vld"}, 64'(bus_if.instr_valid), 64'(1'b1));
        chk({tag, "_pc"},  64'(bus_if.instr_pc), 64'(pc));
        chk({tag, "_ins"}, 64'(bus_if.instr), 64'(ins));
        chk({tag, "_p4"},  64'(bus_if.instr_pc_plus4), 64'(p4));
    endtask

    task automatic do_reset(input logic ready);
        rst = 1'b1;
        bus_if.instr_ready    = ready;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = '0;
        settle();
        chk("rst_req", 64'(bus_if.imem_req), 64'(1'b0));
        chk("rst_vld", 64'(bus_if.instr_valid), 64'(1'b0));
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Streaming after reset
        do_reset(1'b1);
        settle();
        chk("s_c0_req",  64'(bus_if.imem_req), 64'(1'b1));
        chk("s_c0_addr", 64'(bus_if.imem_addr), 64'h0);
        chk("s_c0_vld",  64'(bus_if.instr_valid), 64'(1'b0));
        chk("s_c0_occ",  64'(bus_if.occupancy), 64'h0);
        tick();
        settle();
        chk("s_c1_addr", 64'(bus_if.imem_addr), 64'h4);
        chk("s_c1_vld",  64'(bus_if.instr_valid), 64'(1'b0));
        tick();
        for (int k = 0; k < 8; k++) begin
            settle();
            expect_head($sformatf("s_c%0d", k + 2), 32'(4 * k));
            tick();
        end

        // Backpressure: fill to DEPTH, then drain in order
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("bp_req%0d", k), 64'(bus_if.imem_req), 64'(k < 4));
            if (k < 4) chk($sformatf("bp_addr%0d", k), 64'(bus_if.imem_addr), 64'(4 * k));
            if (k == 7) begin
                chk("bp_occ_full", 64'(bus_if.occupancy), 64'h4);
                expect_head("bp_hold", 32'h0);
            end
            tick();
        end
        bus_if.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            expect_head($sformatf("bp_out%0d", i), 32'(4 * i));
            tick();
        end

        // Redirect with 3 buffered entries and a response arriving
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) tick();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h100;
        bus_if.instr_ready    = 1'b1;
        settle();
        chk("rd_r_occ", 64'(bus_if.occupancy), 64'h3);
        chk("rd_r_vld", 64'(bus_if.instr_valid), 64'(1'b0));
        chk("rd_r_req", 64'(bus_if.imem_req), 64'(1'b0));
        tick();
        bus_if.redirect_valid = 1'b0;
        settle();
        chk("rd_r1_vld",  64'(bus_if.instr_valid), 64'(1'b0));
        chk("rd_r1_req",  64'(bus_if.imem_req), 64'(1'b1));
        chk("rd_r1_addr", 64'(bus_if.imem_addr), 64'h100);
        chk("rd_r1_occ",  64'(bus_if.occupancy), 64'h0);
        tick();
        settle();
        chk("rd_r2_vld", 64'(bus_if.instr_valid), 64'(1'b0));
        chk("rd_r2_occ", 64'(bus_if.occupancy), 64'h0);
        tick();
        settle();
        expect_head("rd_r3", 32'h100);
        tick();
        settle();
        expect_head("rd_r4", 32'h104);
        tick();

        // Misaligned redirect target
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h103;
        settle();
        chk("mis_r_vld", 64'(bus_if.instr_valid), 64'(1'b0));
        tick();
        bus_if.redirect_valid = 1'b0;
        settle();
        chk("mis_r1_req",  64'(bus_if.imem_req), 64'(1'b1));
        chk("mis_r1_addr", 64'(bus_if.imem_addr), 64'h100);
        tick();
        tick();
        settle();
        expect_head("mis_r3", 32'h100);
        tick();
        settle();
        expect_head("mis_r4", 32'h104);
        tick();

        // PC wrap at the top of the address space
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'hFFFF_FFF8;
        settle();
        tick();
        bus_if.redirect_valid = 1'b0;
        settle();
        chk("wr_r1_addr", 64'(bus_if.imem_addr), 64'hFFFF_FFF8);
        tick();
        settle();
        chk("wr_r2_addr", 64'(bus_if.imem_addr), 64'hFFFF_FFFC);
        tick();
        settle();
        chk("wr_r3_addr", 64'(bus_if.imem_addr), 64'h0);
        expect_head("wr_r3", 32'hFFFF_FFF8);
        tick();
        settle();
        expect_head("wr_r4", 32'hFFFF_FFFC);
        tick();
        settle();
        expect_head("wr_r5", 32'h0);
        tick();

        // Back-to-back redirects: last one wins
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h200;
        settle();
        chk("bb_r_req", 64'(bus_if.imem_req), 64'(1'b0));
        tick();
        bus_if.redirect_pc = 32'h300;
        settle();
        chk("bb_r1_req", 64'(bus_if.imem_req), 64'(1'b0));
        chk("bb_r1_vld", 64'(bus_if.instr_valid), 64'(1'b0));
        tick();
        bus_if.redirect_valid = 1'b0;
        settle();
        chk("bb_r2_addr", 64'(bus_if.imem_addr), 64'h300);
        chk("bb_r2_vld",  64'(bus_if.instr_valid), 64'(1'b0));
        tick();
        tick();
        settle();
        expect_head("bb_r4", 32'h300);
        tick();

        // Reset mid-operation with 3 entries buffered and a response arriving
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        settle();
        chk("mr_rst_req", 64'(bus_if.imem_req), 64'(1'b0));
        chk("mr_rst_vld", 64'(bus_if.instr_valid), 64'(1'b0));
        tick();
        rst = 1'b0;
        settle();
        chk("mr_c0_occ",  64'(bus_if.occupancy), 64'h0);
        chk("mr_c0_vld",  64'(bus_if.instr_valid), 64'(1'b0));
        chk("mr_c0_addr", 64'(bus_if.imem_addr), 64'h0);
        chk("mr_c0_req",  64'(bus_if.imem_req), 64'(1'b1));
        tick();
        settle();
        chk("mr_c1_occ", 64'(bus_if.occupancy), 64'h0);
        chk("mr_c1_vld", 64'(bus_if.instr_valid), 64'(1'b0));
        tick();
        settle();
        expect_head("mr_c2", 32'h0);
        chk("mr_c2_occ", 64'(bus_if.occupancy), 64'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
